// File: rtl/maze_solver_walker.sv
`default_nettype none
// ============================================================================
//  Module      : maze_solver_walker
//  Description : Walks a 16x16 maze bitmap from cell (0,0) to a goal cell
//                with a right-hand wall follower. One candidate direction is
//                tested per cycle, and a move commits only on a step_en tick.
//
//  Ports
//    clk, rst           : clock, synchronous active-high reset
//    maze_valid         : carver finish flag (level)
//    maze_data[255:0]   : bit x+16*y, 1 = open cell, 0 = wall
//    start              : solve request (accepted when idle and maze_valid)
//    goal_x, goal_y     : goal cell, captured with start
//    step_en            : pacing tick for committing moves
//    pos_x, pos_y       : current walker cell
//    heading            : 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
//    step_count         : moves committed since start
//    busy, solved, fail : status flags
//
//  Revision    : 1.0  initial release
// ============================================================================
module maze_solver_walker #(
    parameter int         MAX_STEPS     = 1024,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] START_HEADING = 2'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             maze_valid,
    input  logic [255:0]     maze_data,
    input  logic             start,
    input  logic [3:0]       goal_x,
    input  logic [3:0]       goal_y,
    input  logic             step_en,
    output logic [3:0]       pos_x,
    output logic [3:0]       pos_y,
    output logic [1:0]       heading,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             solved,
    output logic             fail
);

    localparam logic [1:0]       c_DIR_N     = 2'd0;
    localparam logic [1:0]       c_DIR_E     = 2'd1;
    localparam logic [1:0]       c_DIR_S     = 2'd2;
    localparam logic [1:0]       c_DIR_W     = 2'd3;
    localparam logic [CNT_W-1:0] c_MAX_STEPS = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MOVE  = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [255:0]     r_maze;
    logic [3:0]       r_goal_x;
    logic [3:0]       r_goal_y;
    logic [3:0]       r_pos_x;
    logic [3:0]       r_pos_y;
    logic [1:0]       r_heading;
    logic [1:0]       r_dir;
    logic [1:0]       r_cand;
    logic [CNT_W-1:0] r_step_count;
    logic             r_busy;
    logic             r_solved;
    logic             r_fail;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t           w_state_next;
    logic             w_accept;
    logic [1:0]       w_cand_off;
    logic [1:0]       w_cand_dir;
    logic [3:0]       w_cand_x;
    logic [3:0]       w_cand_y;
    logic             w_cand_inb;
    logic             w_cand_open;
    logic [3:0]       w_new_x;
    logic [3:0]       w_new_y;
    logic [CNT_W-1:0] w_new_count;
    logic             w_new_at_goal;

    // Neighbour column/row for a step in direction dir. The 4-bit result
    // wraps at the edges; callers gate it with in_bounds().
    function automatic logic [3:0] next_x(input logic [3:0] x, input logic [1:0] dir);
        case (dir)
            c_DIR_E: next_x = x + 4'd1;
            c_DIR_W: next_x = x - 4'd1;
            default: next_x = x;
        endcase
    endfunction

    function automatic logic [3:0] next_y(input logic [3:0] y, input logic [1:0] dir);
        case (dir)
            c_DIR_S: next_y = y + 4'd1;
            c_DIR_N: next_y = y - 4'd1;
            default: next_y = y;
        endcase
    endfunction

    // No wrap-around: stepping off any edge of the grid is treated as a wall.
    function automatic logic in_bounds(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] dir);
        case (dir)
            c_DIR_N: in_bounds = (y != 4'd0);
            c_DIR_E: in_bounds = (x != 4'd15);
            c_DIR_S: in_bounds = (y != 4'd15);
            default: in_bounds = (x != 4'd0);
        endcase
    endfunction

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL))
                      && start && maze_valid;

    // Right-hand rule probe order relative to the current heading:
    // right (+1), straight (+0), left (+3), back (+2).
    always_comb begin
        w_cand_off = 2'd1;
        case (r_cand)
            2'd0:    w_cand_off = 2'd1;
            2'd1:    w_cand_off = 2'd0;
            2'd2:    w_cand_off = 2'd3;
            default: w_cand_off = 2'd2;
        endcase
    end

    assign w_cand_dir  = r_heading + w_cand_off;
    assign w_cand_x    = next_x(r_pos_x, w_cand_dir);
    assign w_cand_y    = next_y(r_pos_y, w_cand_dir);
    assign w_cand_inb  = in_bounds(r_pos_x, r_pos_y, w_cand_dir);
    assign w_cand_open = w_cand_inb && r_maze[{w_cand_y, w_cand_x}];

    // r_dir was proven open in CHECK, so the move target needs no bounds test.
    assign w_new_x       = next_x(r_pos_x, r_dir);
    assign w_new_y       = next_y(r_pos_y, r_dir);
    assign w_new_count   = r_step_count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_new_at_goal = (w_new_x == r_goal_x) && (w_new_y == r_goal_y);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (w_accept) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                // Walker sits at (0,0) here; bit 0 of the snapshot is the start cell.
                if (!r_maze[0]) begin
                    w_state_next = S_FAIL;
                end else if ((r_goal_x == 4'd0) && (r_goal_y == 4'd0)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_cand_open) begin
                    w_state_next = S_MOVE;
                end else if (r_cand == 2'd3) begin
                    w_state_next = S_FAIL;
                end
            end
            S_MOVE: begin
                if (step_en) begin
                    if (w_new_at_goal) begin
                        w_state_next = S_DONE;
                    end else if (w_new_count == c_MAX_STEPS) begin
                        w_state_next = S_FAIL;
                    end else begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_maze       <= '0;
            r_goal_x     <= 4'd0;
            r_goal_y     <= 4'd0;
            r_pos_x      <= 4'd0;
            r_pos_y      <= 4'd0;
            r_heading    <= START_HEADING;
            r_dir        <= 2'd0;
            r_cand       <= 2'd0;
            r_step_count <= '0;
            r_busy       <= 1'b0;
            r_solved     <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Snapshot so later changes on the carver side are ignored.
                r_maze       <= maze_data;
                r_goal_x     <= goal_x;
                r_goal_y     <= goal_y;
                r_pos_x      <= 4'd0;
                r_pos_y      <= 4'd0;
                r_heading    <= START_HEADING;
                r_cand       <= 2'd0;
                r_step_count <= '0;
                r_busy       <= 1'b1;
                r_solved     <= 1'b0;
                r_fail       <= 1'b0;
            end else begin
                case (r_state)
                    S_CHECK: begin
                        if (w_cand_open) begin
                            r_dir <= w_cand_dir;
                        end else begin
                            r_cand <= r_cand + 2'd1;
                        end
                    end
                    S_MOVE: begin
                        if (step_en) begin
                            r_pos_x      <= w_new_x;
                            r_pos_y      <= w_new_y;
                            r_heading    <= r_dir;
                            r_step_count <= w_new_count;
                            r_cand       <= 2'd0;
                        end
                    end
                    default: begin
                    end
                endcase
                // Terminal flags are set on the edge that enters DONE/FAIL so
                // they are visible together with the state they report.
                if (w_state_next == S_DONE) begin
                    r_solved <= 1'b1;
                    r_busy   <= 1'b0;
                end
                if (w_state_next == S_FAIL) begin
                    r_fail <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign heading    = r_heading;
    assign step_count = r_step_count;
    assign busy       = r_busy;
    assign solved     = r_solved;
    assign fail       = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_maze_solver_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_solver_walker
//  Description : Self-checking bench for maze_solver_walker. A table of
//                maze scenarios with hand-derived final states is pushed to
//                a scoreboard queue at start and popped when the walker
//                goes idle; hand-written sequences cover start gating,
//                fail timing, start-while-busy and mid-solve reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maze_solver_walker;

    localparam int c_MS = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         maze_valid;
    logic [255:0] maze_data;
    logic         start;
    logic [3:0]   goal_x;
    logic [3:0]   goal_y;
    logic         step_en;
    logic [3:0]   pos_x;
    logic [3:0]   pos_y;
    logic [1:0]   heading;
    logic [15:0]  step_count;
    logic         busy;
    logic         solved;
    logic         fail;

    always #5 clk = ~clk;

    maze_solver_walker #(
        .MAX_STEPS    (c_MS),
        .CNT_W        (16),
        .START_HEADING(2'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .maze_valid(maze_valid),
        .maze_data (maze_data),
        .start     (start),
        .goal_x    (goal_x),
        .goal_y    (goal_y),
        .step_en   (step_en),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .heading   (heading),
        .step_count(step_count),
        .busy      (busy),
        .solved    (solved),
        .fail      (fail)
    );

    typedef struct {
        logic [255:0] maze;
        logic [3:0]   gx;
        logic [3:0]   gy;
        int           step_div;
        int           e_solved;
        int           e_fail;
        int           e_x;
        int           e_y;
        int           e_h;
        int           e_cnt;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] open_cell(input logic [255:0] m, input int x, input int y);
        logic [255:0] r;
        r = m;
        r[x + 16*y] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] row0(input int last_x);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i <= last_x; i++) r = open_cell(r, i, 0);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x"},    int'(pos_x), 0);
        chk({tag, "_y"},    int'(pos_y), 0);
        chk({tag, "_hd"},   int'(heading), 1);
        chk({tag, "_cnt"},  int'(step_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_slv"},  int'(solved), 0);
        chk({tag, "_fail"}, int'(fail), 0);
    endtask

    // Runs until busy drops, checking that step_count only ever advances by
    // one and only on an edge where step_en was high.
    task automatic wait_idle(input int step_div, output bit ok);
        int          cyc;
        bit          se;
        logic [15:0] prev;
        ok   = 1'b0;
        cyc  = 0;
        prev = step_count;
        while (!ok && cyc < 3000) begin
            step_en = ((cyc % step_div) == 0);
            se      = step_en;
            tick();
            cyc++;
            if (step_count != prev) begin
                chk("one_move_per_tick", int'(step_count), se ? int'(prev) + 1 : int'(prev));
            end
            prev = step_count;
            if (!busy) ok = 1'b1;
        end
        step_en = 1'b0;
        if (!ok) chk("timeout_busy", int'(busy), 0);
    endtask

    task automatic compare_result(input int id);
        vec_t e;
        string t;
        e = sb.pop_front();
        t = $sformatf("v%0d", id);
        chk({t, "_solved"}, int'(solved), e.e_solved);
        chk({t, "_fail"},   int'(fail), e.e_fail);
        chk({t, "_x"},      int'(pos_x), e.e_x);
        chk({t, "_y"},      int'(pos_y), e.e_y);
        chk({t, "_hd"},     int'(heading), e.e_h);
        chk({t, "_cnt"},    int'(step_count), e.e_cnt);
        chk({t, "_excl"},   int'(solved && fail), 0);
    endtask

    task automatic run_vec(input int id);
        bit ok;
        maze_data  = vecs[id].maze;
        maze_valid = 1'b1;
        goal_x     = vecs[id].gx;
        goal_y     = vecs[id].gy;
        start      = 1'b1;
        step_en    = 1'b0;
        tick();
        start = 1'b0;
        // Scrambling the inputs after acceptance must not matter.
        maze_valid = 1'b0;
        maze_data  = '0;
        sb.push_back(vecs[id]);
        chk($sformatf("v%0d_busy_after_accept", id), int'(busy), 1);
        wait_idle(vecs[id].step_div, ok);
        compare_result(id);
    endtask

    initial begin
        bit ok;
        //            maze                                         gx gy div slv fl  x  y  h cnt
        vecs[0] = '{row0(5),                                       5, 0, 1, 1, 0,  5, 0, 1, 5};
        vecs[1] = '{256'd0,                                        3, 3, 1, 0, 1,  0, 0, 1, 0};
        vecs[2] = '{row0(1),                                       3, 3, 1, 0, 1,  0, 0, 3, c_MS};
        vecs[3] = '{open_cell(row0(15), 0, 1),                     0, 1, 1, 1, 0,  0, 1, 2, 1};
        vecs[4] = '{row0(15),                                      0, 1, 1, 0, 1, 10, 0, 1, c_MS};
        vecs[5] = '{row0(5),                                       5, 0, 4, 1, 0,  5, 0, 1, 5};
        vecs[6] = '{row0(3),                                       0, 0, 1, 1, 0,  0, 0, 1, 0};
        vecs[7] = '{open_cell(open_cell(row0(0), 0, 1), 1, 1),     1, 1, 1, 1, 0,  1, 1, 1, 2};

        rst = 1'b1; maze_valid = 1'b0; maze_data = '0; start = 1'b0;
        goal_x = 4'd0; goal_y = 4'd0; step_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // start without maze_valid is ignored
        maze_data = row0(5); goal_x = 4'd5; start = 1'b1; maze_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("start_no_valid_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Closed start cell: fail high two cycles after the accepting edge,
        // previous solved flag cleared on acceptance.
        maze_data = '0; maze_valid = 1'b1; goal_x = 4'd3; goal_y = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("closed_solved_cleared", int'(solved), 0);
        chk("closed_busy", int'(busy), 1);
        tick();
        tick();
        chk("closed_fail", int'(fail), 1);
        chk("closed_busy_low", int'(busy), 0);

        // start while busy is ignored; no move without step_en
        maze_data = row0(5); maze_valid = 1'b1; goal_x = 4'd5; goal_y = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("hold_no_step_cnt", int'(step_count), 0);
        chk("hold_busy", int'(busy), 1);
        goal_x = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(vecs[0]);
        wait_idle(1, ok);
        compare_result(100);

        // Reset mid-solve, then a fresh solve
        maze_data = row0(5); maze_valid = 1'b1; goal_x = 4'd5; goal_y = 4'd0; start = 1'b1;
        tick();
        start = 1'b0; step_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_moved", int'(step_count != 0), 1);
        rst = 1'b1; step_en = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
